// File: rtl/id_pipe_ctrl_if.sv
// rtl/id_pipe_ctrl_if.sv - decode-stage pipeline control signal bundle
//
// Purpose: groups the fetch/decode, ID/EX, execute and trap-unit signals
// that the decode-stage controller observes and drives.
// Modports:
//   master - pipeline side: drives the i_* inputs, observes the o_* outputs
//   slave  - id_pipe_ctrl: observes the i_* inputs, drives the o_* outputs
interface id_pipe_ctrl_if #(
   parameter int RegAddrWidth = 5
);
   logic                    i_if_valid;
   logic [RegAddrWidth-1:0] i_rs1_addr;
   logic [RegAddrWidth-1:0] i_rs2_addr;
   logic                    i_rs1_used;
   logic                    i_rs2_used;
   logic                    i_illegal;
   logic                    i_idex_load;
   logic [RegAddrWidth-1:0] i_idex_rd_addr;
   logic                    i_ex_ready;
   logic                    i_br_taken;
   logic                    i_trap_ack;
   logic                    o_id_load;
   logic                    o_id_valid;
   logic                    o_if_stall;
   logic                    o_if_flush;
   logic                    o_trap_req;
   logic [15:0]             o_lu_stall_cnt;

   modport master (
      output i_if_valid, i_rs1_addr, i_rs2_addr, i_rs1_used, i_rs2_used,
             i_illegal, i_idex_load, i_idex_rd_addr, i_ex_ready,
             i_br_taken, i_trap_ack,
      input  o_id_load, o_id_valid, o_if_stall, o_if_flush, o_trap_req,
             o_lu_stall_cnt
   );

   modport slave (
      input  i_if_valid, i_rs1_addr, i_rs2_addr, i_rs1_used, i_rs2_used,
             i_illegal, i_idex_load, i_idex_rd_addr, i_ex_ready,
             i_br_taken, i_trap_ack,
      output o_id_load, o_id_valid, o_if_stall, o_if_flush, o_trap_req,
             o_lu_stall_cnt
   );
endinterface

// File: rtl/id_pipe_ctrl.sv
// rtl/id_pipe_ctrl.sv - decode-stage hazard, drain and trap controller
//
// Purpose: controls the ID/EX pipeline register. Inserts a one-cycle bubble
// on load-use hazards, drains older instructions for DrainCycles accepted
// cycles after an illegal instruction, then requests a trap and waits for
// the trap unit. A taken branch flushes and returns to RUN from any state.
// Ports:
//   clk  - clock, all state on rising edge
//   rst  - asynchronous active-high reset
//   bus  - id_pipe_ctrl_if.slave (fetch/decode, ID/EX, execute, trap signals)
module id_pipe_ctrl #(
   parameter int RegAddrWidth = 5,
   parameter int DrainCycles  = 3
) (
   input logic          clk,
   input logic          rst,
   id_pipe_ctrl_if.slave bus
);

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      DRAIN = 2'd1,
      TRAP  = 2'd2
   } state_e;

   localparam logic [3:0] DrainInit = 4'(DrainCycles - 1);

   state_e      state_q;
   logic [3:0]  drain_cnt_q;
   logic        id_valid_q;
   logic        trap_req_q;
   logic [15:0] lu_cnt_q;
   logic [15:0] lu_cnt_d;

   logic        hazard;
   logic        rs1_match;
   logic        rs2_match;
   logic        if_stall;
   logic        if_flush;

   // Hazard looks at the ID/EX valid bit as seen on the bus so the decode
   // comparison always uses exactly what downstream logic observes.
   assign rs1_match = bus.i_rs1_used && (bus.i_rs1_addr == bus.i_idex_rd_addr);
   assign rs2_match = bus.i_rs2_used && (bus.i_rs2_addr == bus.i_idex_rd_addr);
   assign hazard    = bus.i_if_valid && bus.o_id_valid && bus.i_idex_load &&
                      (bus.i_idex_rd_addr != '0) && (rs1_match || rs2_match);

   // Saturating increment: the stall counter sticks at all-ones.
   assign lu_cnt_d = (lu_cnt_q == 16'hFFFF) ? lu_cnt_q : lu_cnt_q + 16'd1;

   always_comb begin
      if_stall = 1'b0;
      if_flush = 1'b0;
      if (rst) begin
         if_stall = 1'b1;
      end else if (bus.i_br_taken) begin
         if_flush = 1'b1;
      end else if (state_q != RUN) begin
         if_stall = 1'b1;
         if ((state_q == TRAP) && bus.i_trap_ack) begin
            if_flush = 1'b1;
         end
      end else if (!bus.i_ex_ready || hazard || (bus.i_if_valid && bus.i_illegal)) begin
         if_stall = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= RUN;
         drain_cnt_q <= '0;
         id_valid_q  <= 1'b0;
         trap_req_q  <= 1'b0;
         lu_cnt_q    <= '0;
      end else if (bus.i_br_taken) begin
         state_q     <= RUN;
         drain_cnt_q <= '0;
         id_valid_q  <= 1'b0;
         trap_req_q  <= 1'b0;
      end else begin
         unique case (state_q)
            RUN: begin
               // Not accepted by execute: everything holds.
               if (bus.i_ex_ready) begin
                  if (hazard) begin
                     id_valid_q <= 1'b0;
                     lu_cnt_q   <= lu_cnt_d;
                  end else if (bus.i_if_valid && bus.i_illegal) begin
                     id_valid_q  <= 1'b0;
                     state_q     <= DRAIN;
                     drain_cnt_q <= DrainInit;
                  end else begin
                     id_valid_q <= bus.i_if_valid;
                  end
               end
            end
            DRAIN: begin
               id_valid_q <= 1'b0;
               if (bus.i_ex_ready) begin
                  if (drain_cnt_q == 4'd0) begin
                     state_q    <= TRAP;
                     trap_req_q <= 1'b1;
                  end else begin
                     drain_cnt_q <= drain_cnt_q - 4'd1;
                  end
               end
            end
            TRAP: begin
               id_valid_q <= 1'b0;
               if (bus.i_trap_ack) begin
                  state_q    <= RUN;
                  trap_req_q <= 1'b0;
               end
            end
            default: begin
               state_q     <= RUN;
               drain_cnt_q <= '0;
               id_valid_q  <= 1'b0;
               trap_req_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.o_id_load      = bus.i_ex_ready || bus.i_br_taken;
   assign bus.o_id_valid     = id_valid_q;
   assign bus.o_if_stall     = if_stall;
   assign bus.o_if_flush     = if_flush;
   assign bus.o_trap_req     = trap_req_q;
   assign bus.o_lu_stall_cnt = lu_cnt_q;

endmodule

// File: tb/tb_id_pipe_ctrl.sv
// tb/tb_id_pipe_ctrl.sv - self-checking bench for id_pipe_ctrl
module tb_id_pipe_ctrl;

   localparam int AW    = 5;
   localparam int DRAIN = 3;

   logic clk;
   logic rst;
   int   total;
   int   bad;

   // Reference model: ID/EX valid, stall count, drain cycles still owed,
   // and whether a trap request is outstanding.
   bit   m_valid;
   int   m_lu;
   int   m_drain;
   bit   m_trap;

   id_pipe_ctrl_if #(.RegAddrWidth(AW)) intf ();

   id_pipe_ctrl #(
      .RegAddrWidth(AW),
      .DrainCycles (DRAIN)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(intf.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_valid = 1'b0;
      m_lu    = 0;
      m_drain = 0;
      m_trap  = 1'b0;
   endtask

   task automatic idle_inputs();
      intf.i_if_valid     = 1'b0;
      intf.i_rs1_addr     = '0;
      intf.i_rs2_addr     = '0;
      intf.i_rs1_used     = 1'b0;
      intf.i_rs2_used     = 1'b0;
      intf.i_illegal      = 1'b0;
      intf.i_idex_load    = 1'b0;
      intf.i_idex_rd_addr = '0;
      intf.i_ex_ready     = 1'b1;
      intf.i_br_taken     = 1'b0;
      intf.i_trap_ack     = 1'b0;
   endtask

   task automatic rand_inputs();
      intf.i_if_valid     = ($urandom_range(3) != 0);
      intf.i_rs1_addr     = AW'($urandom_range(3));
      intf.i_rs2_addr     = AW'($urandom_range(3));
      intf.i_rs1_used     = ($urandom_range(1) != 0);
      intf.i_rs2_used     = ($urandom_range(1) != 0);
      intf.i_illegal      = ($urandom_range(15) == 0);
      intf.i_idex_load    = ($urandom_range(1) != 0);
      intf.i_idex_rd_addr = AW'($urandom_range(3));
      intf.i_ex_ready     = ($urandom_range(3) != 0);
      intf.i_br_taken     = ($urandom_range(31) == 0);
      intf.i_trap_ack     = ($urandom_range(3) == 0);
      rst                 = ($urandom_range(255) == 0);
   endtask

   // Called just after a falling edge with inputs already driven: checks all
   // outputs against the model, then advances the model over the rising edge.
   task automatic do_cycle();
      bit hz;
      bit busy;
      bit e_stall;
      bit e_flush;
      #1;
      if (rst) model_reset();
      hz = intf.i_if_valid && m_valid && intf.i_idex_load && (intf.i_idex_rd_addr != 0) &&
           ((intf.i_rs1_used && intf.i_rs1_addr == intf.i_idex_rd_addr) ||
            (intf.i_rs2_used && intf.i_rs2_addr == intf.i_idex_rd_addr));
      busy = m_trap || (m_drain > 0);
      if (rst) begin
         e_stall = 1'b1;
         e_flush = 1'b0;
      end else if (intf.i_br_taken) begin
         e_stall = 1'b0;
         e_flush = 1'b1;
      end else begin
         e_stall = busy || !intf.i_ex_ready || hz || (intf.i_if_valid && intf.i_illegal);
         e_flush = m_trap && intf.i_trap_ack;
      end
      chk("id_valid", 32'(intf.o_id_valid), 32'(m_valid));
      chk("lu_cnt", 32'(intf.o_lu_stall_cnt), 32'(m_lu));
      chk("trap_req", 32'(intf.o_trap_req), 32'(m_trap));
      chk("if_stall", 32'(intf.o_if_stall), 32'(e_stall));
      chk("if_flush", 32'(intf.o_if_flush), 32'(e_flush));
      chk("id_load", 32'(intf.o_id_load), 32'(intf.i_ex_ready || intf.i_br_taken));
      @(posedge clk);
      if (!rst) begin
         if (intf.i_br_taken) begin
            m_valid = 1'b0;
            m_drain = 0;
            m_trap  = 1'b0;
         end else if (m_trap) begin
            m_valid = 1'b0;
            if (intf.i_trap_ack) m_trap = 1'b0;
         end else if (m_drain > 0) begin
            m_valid = 1'b0;
            if (intf.i_ex_ready) begin
               m_drain--;
               if (m_drain == 0) m_trap = 1'b1;
            end
         end else if (!intf.i_ex_ready) begin
            m_valid = m_valid;
         end else if (hz) begin
            m_valid = 1'b0;
            if (m_lu < 65535) m_lu++;
         end else if (intf.i_if_valid && intf.i_illegal) begin
            m_valid = 1'b0;
            m_drain = DRAIN;
         end else begin
            m_valid = intf.i_if_valid;
         end
      end
      @(negedge clk);
   endtask

   task automatic issue_legal();
      idle_inputs();
      intf.i_if_valid = 1'b1;
      do_cycle();
   endtask

   initial begin
      total = 0;
      bad   = 0;
      model_reset();
      idle_inputs();
      rst = 1'b1;
      @(negedge clk);
      do_cycle();
      do_cycle();
      rst = 1'b0;

      // Load rd=x0 feeding a consumer of x0: no stall.
      issue_legal();
      idle_inputs();
      intf.i_if_valid     = 1'b1;
      intf.i_idex_load    = 1'b1;
      intf.i_rs1_used     = 1'b1;
      #1 chk("x0_no_stall", 32'(intf.o_if_stall), 32'd0);
      do_cycle();
      chk("x0_valid", 32'(intf.o_id_valid), 32'd1);

      // Load x5 feeding rs1=x5: exactly one bubble.
      intf.i_idex_rd_addr = AW'(5);
      intf.i_rs1_addr     = AW'(5);
      #1 chk("lu_stall", 32'(intf.o_if_stall), 32'd1);
      do_cycle();
      chk("lu_bubble", 32'(intf.o_id_valid), 32'd0);
      chk("lu_cnt_one", 32'(intf.o_lu_stall_cnt), 32'd1);
      #1 chk("lu_clear", 32'(intf.o_if_stall), 32'd0);
      do_cycle();

      // Execute back-pressure holds a valid ID/EX.
      issue_legal();
      idle_inputs();
      intf.i_if_valid = 1'b1;
      intf.i_ex_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         do_cycle();
         chk("hold_valid", 32'(intf.o_id_valid), 32'd1);
      end

      // Illegal instruction: three drain cycles, trap, ack flushes.
      idle_inputs();
      intf.i_if_valid = 1'b1;
      intf.i_illegal  = 1'b1;
      do_cycle();
      idle_inputs();
      for (int i = 0; i < DRAIN; i++) begin
         chk("drain_no_trap", 32'(intf.o_trap_req), 32'd0);
         do_cycle();
      end
      chk("trap_req_on", 32'(intf.o_trap_req), 32'd1);
      do_cycle();
      intf.i_trap_ack = 1'b1;
      #1 chk("ack_flush", 32'(intf.o_if_flush), 32'd1);
      do_cycle();
      chk("trap_released", 32'(intf.o_trap_req), 32'd0);

      // Branch during drain aborts the trap.
      idle_inputs();
      intf.i_if_valid = 1'b1;
      intf.i_illegal  = 1'b1;
      do_cycle();
      idle_inputs();
      do_cycle();
      intf.i_br_taken = 1'b1;
      #1 chk("br_flush", 32'(intf.o_if_flush), 32'd1);
      do_cycle();
      idle_inputs();
      for (int i = 0; i < 6; i++) do_cycle();
      chk("br_no_trap", 32'(intf.o_trap_req), 32'd0);

      // Randomized traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         rand_inputs();
         do_cycle();
      end
      rst = 1'b0;

      // Saturation: hold ID/EX valid so every cycle is a load-use hazard.
      idle_inputs();
      rst = 1'b1;
      do_cycle();
      rst = 1'b0;
      force intf.o_id_valid = 1'b1;
      intf.i_if_valid     = 1'b1;
      intf.i_idex_load    = 1'b1;
      intf.i_idex_rd_addr = AW'(5);
      intf.i_rs1_addr     = AW'(5);
      intf.i_rs1_used     = 1'b1;
      repeat (32'hFFFE) @(posedge clk);
      @(negedge clk);
      chk("lu_near_sat", 32'(intf.o_lu_stall_cnt), 32'hFFFE);
      repeat (7) @(posedge clk);
      @(negedge clk);
      chk("lu_sat", 32'(intf.o_lu_stall_cnt), 32'hFFFF);
      release intf.o_id_valid;
      idle_inputs();
      m_valid = 1'b0;
      m_lu    = 65535;
      m_drain = 0;
      m_trap  = 1'b0;
      do_cycle();

      // Reset pulse while trapping clears everything, no late trap request.
      intf.i_if_valid = 1'b1;
      intf.i_illegal  = 1'b1;
      do_cycle();
      idle_inputs();
      for (int i = 0; i < DRAIN; i++) do_cycle();
      chk("pre_rst_trap", 32'(intf.o_trap_req), 32'd1);
      rst = 1'b1;
      #1 chk("rst_trap_req", 32'(intf.o_trap_req), 32'd0);
      chk("rst_lu_cnt", 32'(intf.o_lu_stall_cnt), 32'd0);
      do_cycle();
      rst = 1'b0;
      for (int i = 0; i < 6; i++) do_cycle();
      chk("post_rst_no_trap", 32'(intf.o_trap_req), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
